snake_body_engine: RTL

- Parametrised successor to the single-block snake datapath/control pair.
- Tracks a multi-segment snake in a circular coordinate buffer and on each step pulse checks for collisions.
- Erases the tail, draws the new head, and grows the snake on food.
- Emits the same per-pixel (x, y, colour, plot) stream the 160x120 VGA adapter consumes; sits between the keyboard/rate-divider front end and the adapter.

---
 rtl/snake_body_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Multi-segment snake engine. Segment coordinates live in a circular buffer
//   (tail_ptr .. head_ptr). On each accepted step pulse the engine computes the
//   next head position and checks it against the screen edge and against every
//   body segment, one segment per cycle. It then erases the tail (or grows) and
//   draws the new head. The result is a per-pixel (x, y, colour, plot) stream
//   for a 160x120 VGA adapter. Each block is BLK x BLK pixels.
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   tick       step request pulse; only accepted in WAIT
//   dir_valid  dir_req is valid this cycle
//   dir_req    00 right, 01 left, 10 up (y-BLK), 11 down (y+BLK)
//   food_x/y   food block position, BLK-aligned
//   x_out/y_out/colour/plot  registered pixel stream to the adapter
//   ate        one-cycle pulse when food is eaten
//   game_over  level, set on collision
//   busy       high outside WAIT/HALT, aligned with the visible pixel stream
//   length     current segment count
module snake_body_engine #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int BLK_LOG2  = 2,
    parameter int LEN_LOG2  = 4,
    parameter int X_LIM     = 160,
    parameter int Y_LIM     = 120,
    parameter int START_X   = 80,
    parameter int START_Y   = 60,
    parameter int START_LEN = 3,
    parameter int WRAP      = 0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                tick,
    input  logic                dir_valid,
    input  logic [1:0]          dir_req,
    input  logic [X_W-1:0]      food_x,
    input  logic [Y_W-1:0]      food_y,
    output logic [X_W-1:0]      x_out,
    output logic [Y_W-1:0]      y_out,
    output logic [2:0]          colour,
    output logic                plot,
    output logic                ate,
    output logic                game_over,
    output logic                busy,
    output logic [LEN_LOG2:0]   length
);
    localparam int BLK     = 1 << BLK_LOG2;
    localparam int MAX_LEN = 1 << LEN_LOG2;
    localparam int PIX_W   = 2 * BLK_LOG2;
    localparam int LEN_W   = LEN_LOG2 + 1;
    localparam int PTR_W   = LEN_LOG2;

    localparam logic [X_W-1:0]   X_BLK    = X_W'(BLK);
    localparam logic [X_W-1:0]   X_MAX    = X_W'(X_LIM - BLK);
    localparam logic [Y_W-1:0]   Y_BLK    = Y_W'(BLK);
    localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(Y_LIM - BLK);
    localparam logic [PIX_W-1:0] PIX_LAST = {PIX_W{1'b1}};
    localparam logic [PIX_W-1:0] PIX_ZERO = {PIX_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(START_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [2:0]       COL_BLACK = 3'b000;
    localparam logic [2:0]       COL_GREEN = 3'b010;
    localparam logic [2:0]       COL_RED   = 3'b100;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_WAIT  = 3'd1,
        S_CHECK = 3'd2,
        S_ERASE = 3'd3,
        S_GROW  = 3'd4,
        S_HEAD  = 3'd5,
        S_DEAD  = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    state_t             state_q;
    logic [PIX_W-1:0]   pix_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [1:0]         dir_q;
    logic [LEN_W-1:0]   length_q;
    logic [PTR_W-1:0]   tail_ptr_q;
    logic [PTR_W-1:0]   head_ptr_q;
    logic [X_W-1:0]     seg_x_q [MAX_LEN];
    logic [Y_W-1:0]     seg_y_q [MAX_LEN];
    logic [X_W-1:0]     nxt_x_q;
    logic [Y_W-1:0]     nxt_y_q;
    logic               eat_q;
    logic               bound_q;
    logic               hit_q;

    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic [2:0]         colour_q;
    logic               plot_q;
    logic               ate_q;
    logic               game_over_q;
    logic               busy_q;

    logic [PTR_W-1:0]   rd_idx_s;
    logic [X_W-1:0]     rd_x_s;
    logic [Y_W-1:0]     rd_y_s;
    logic [X_W-1:0]     head_x_s;
    logic [Y_W-1:0]     head_y_s;
    logic [X_W-1:0]     step_x_s;
    logic [Y_W-1:0]     step_y_s;
    logic               step_oob_s;
    logic               hit_now_s;
    logic               last_chk_s;
    logic               full_s;

    logic [X_W-1:0]     x_d;
    logic [Y_W-1:0]     y_d;
    logic [2:0]         colour_d;
    logic               plot_d;
    logic               ate_d;
    logic               game_over_d;
    logic               busy_d;
    logic [X_W-1:0]     base_x_s;
    logic [Y_W-1:0]     base_y_s;

    // Buffer read port: which segment the current state is looking at
    always_comb begin
        rd_idx_s = head_ptr_q;
        case (state_q)
            S_INIT:          rd_idx_s = cnt_q[PTR_W-1:0];
            S_CHECK:         rd_idx_s = tail_ptr_q + cnt_q[PTR_W-1:0];
            S_ERASE, S_GROW: rd_idx_s = tail_ptr_q;
            default:         rd_idx_s = head_ptr_q;
        endcase
        rd_x_s   = seg_x_q[rd_idx_s];
        rd_y_s   = seg_y_q[rd_idx_s];
        head_x_s = seg_x_q[head_ptr_q];
        head_y_s = seg_y_q[head_ptr_q];
    end

    // Candidate next head; edges are detected before the add so nothing overflows
    always_comb begin
        step_x_s   = head_x_s;
        step_y_s   = head_y_s;
        step_oob_s = 1'b0;
        case (dir_q)
            2'b00: begin
                if (head_x_s >= X_MAX) begin
                    step_oob_s = 1'b1;
                    step_x_s   = {X_W{1'b0}};
                end else begin
                    step_x_s   = head_x_s + X_BLK;
                end
            end
            2'b01: begin
                if (head_x_s < X_BLK) begin
                    step_oob_s = 1'b1;
                    step_x_s   = X_MAX;
                end else begin
                    step_x_s   = head_x_s - X_BLK;
                end
            end
            2'b10: begin
                if (head_y_s < Y_BLK) begin
                    step_oob_s = 1'b1;
                    step_y_s   = Y_MAX;
                end else begin
                    step_y_s   = head_y_s - Y_BLK;
                end
            end
            2'b11: begin
                if (head_y_s >= Y_MAX) begin
                    step_oob_s = 1'b1;
                    step_y_s   = {Y_W{1'b0}};
                end else begin
                    step_y_s   = head_y_s + Y_BLK;
                end
            end
            default: begin
                step_oob_s = 1'b0;
            end
        endcase
    end

    // Collision compare; the tail (cnt 0) only counts when it does not vacate
    always_comb begin
        hit_now_s  = (state_q == S_CHECK) && (rd_x_s == nxt_x_q) && (rd_y_s == nxt_y_q)
                     && (eat_q || (cnt_q != LEN_ZERO));
        last_chk_s = (cnt_q == (length_q - LEN_ONE));
        full_s     = (length_q == LEN_FULL);
    end

    // Pixel stream next values, derived from the current state and pixel counter
    always_comb begin
        base_x_s = rd_x_s;
        base_y_s = rd_y_s;
        plot_d   = 1'b0;
        colour_d = COL_BLACK;
        case (state_q)
            S_INIT: begin
                plot_d   = 1'b1;
                colour_d = COL_GREEN;
            end
            S_ERASE: begin
                plot_d   = 1'b1;
                colour_d = COL_BLACK;
            end
            S_GROW: begin
                plot_d   = full_s;
                colour_d = COL_BLACK;
            end
            S_HEAD: begin
                plot_d   = 1'b1;
                colour_d = COL_GREEN;
                base_x_s = nxt_x_q;
                base_y_s = nxt_y_q;
            end
            S_DEAD: begin
                plot_d   = 1'b1;
                colour_d = COL_RED;
            end
            default: begin
                plot_d   = 1'b0;
            end
        endcase
        if (plot_d) begin
            x_d = base_x_s + X_W'(pix_q[BLK_LOG2-1:0]);
            y_d = base_y_s + Y_W'(pix_q[PIX_W-1:BLK_LOG2]);
        end else begin
            x_d      = {X_W{1'b0}};
            y_d      = {Y_W{1'b0}};
            colour_d = COL_BLACK;
        end
        ate_d       = (state_q == S_GROW) && (pix_q == PIX_ZERO);
        game_over_d = (state_q == S_DEAD) || (state_q == S_HALT);
        busy_d      = (state_q != S_WAIT) && (state_q != S_HALT);
    end

    // Control FSM, segment buffer and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_INIT;
            pix_q       <= PIX_ZERO;
            cnt_q       <= LEN_ZERO;
            dir_q       <= 2'b00;
            length_q    <= LEN_INIT;
            tail_ptr_q  <= {PTR_W{1'b0}};
            head_ptr_q  <= PTR_W'(START_LEN - 1);
            nxt_x_q     <= {X_W{1'b0}};
            nxt_y_q     <= {Y_W{1'b0}};
            eat_q       <= 1'b0;
            bound_q     <= 1'b0;
            hit_q       <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                if (i < START_LEN) begin
                    seg_x_q[i] <= X_W'(START_X - (START_LEN - 1 - i) * BLK);
                    seg_y_q[i] <= Y_W'(START_Y);
                end else begin
                    seg_x_q[i] <= {X_W{1'b0}};
                    seg_y_q[i] <= {Y_W{1'b0}};
                end
            end
            x_q         <= {X_W{1'b0}};
            y_q         <= {Y_W{1'b0}};
            colour_q    <= COL_BLACK;
            plot_q      <= 1'b0;
            ate_q       <= 1'b0;
            game_over_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            plot_q      <= plot_d;
            ate_q       <= ate_d;
            game_over_q <= game_over_d;
            busy_q      <= busy_d;

            // A reversal would run the head straight into the neck; drop it
            if ((state_q != S_HALT) && dir_valid && (dir_req != (dir_q ^ 2'b01))) begin
                dir_q <= dir_req;
            end

            case (state_q)
                S_INIT: begin
                    pix_q <= pix_q + 1'b1;
                    if (pix_q == PIX_LAST) begin
                        if (cnt_q == (LEN_INIT - LEN_ONE)) begin
                            cnt_q   <= LEN_ZERO;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q   <= cnt_q + LEN_ONE;
                        end
                    end
                end
                S_WAIT: begin
                    if (tick) begin
                        nxt_x_q <= step_x_s;
                        nxt_y_q <= step_y_s;
                        bound_q <= step_oob_s && (WRAP == 0);
                        eat_q   <= (step_x_s == food_x) && (step_y_s == food_y);
                        hit_q   <= 1'b0;
                        cnt_q   <= LEN_ZERO;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (last_chk_s) begin
                        cnt_q <= LEN_ZERO;
                        pix_q <= PIX_ZERO;
                        if (hit_q || hit_now_s || bound_q) begin
                            state_q <= S_DEAD;
                        end else if (eat_q) begin
                            state_q <= S_GROW;
                        end else begin
                            state_q <= S_ERASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + LEN_ONE;
                        hit_q <= hit_q || hit_now_s;
                    end
                end
                S_ERASE: begin
                    pix_q <= pix_q + 1'b1;
                    if (pix_q == PIX_LAST) begin
                        tail_ptr_q <= tail_ptr_q + PTR_ONE;
                        state_q    <= S_HEAD;
                    end
                end
                S_GROW: begin
                    // A full buffer cannot grow: erase the tail as a normal move
                    if (!full_s) begin
                        length_q <= length_q + LEN_ONE;
                        state_q  <= S_HEAD;
                    end else begin
                        pix_q <= pix_q + 1'b1;
                        if (pix_q == PIX_LAST) begin
                            tail_ptr_q <= tail_ptr_q + PTR_ONE;
                            state_q    <= S_HEAD;
                        end
                    end
                end
                S_HEAD: begin
                    pix_q <= pix_q + 1'b1;
                    if (pix_q == PIX_LAST) begin
                        head_ptr_q                   <= head_ptr_q + PTR_ONE;
                        seg_x_q[head_ptr_q + PTR_ONE] <= nxt_x_q;
                        seg_y_q[head_ptr_q + PTR_ONE] <= nxt_y_q;
                        state_q                      <= S_WAIT;
                    end
                end
                S_DEAD: begin
                    pix_q <= pix_q + 1'b1;
                    if (pix_q == PIX_LAST) begin
                        state_q <= S_HALT;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_HALT;
                end
            endcase
        end
    end

    assign x_out     = x_q;
    assign y_out     = y_q;
    assign colour    = colour_q;
    assign plot      = plot_q;
    assign ate       = ate_q;
    assign game_over = game_over_q;
    assign busy      = busy_q;
    assign length    = length_q;

endmodule
